// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation
// encodings (also used by the controller that drives md_op) and default
// latencies. Optional multiply-accumulate support is enabled by MDU_MADD_EN.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8
    } md_op_e;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    // True for operations that occupy the unit for a busy period.
    function automatic logic is_multi_cycle(input logic [3:0] op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU:                  return 1'b1;
`endif
            default:                            return 1'b0;
        endcase
    endfunction

    // True for operations that use the divide latency.
    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational datapath of the multiply/divide unit. Produces the 64-bit
// {HI,LO} value that will commit when the busy period ends, including the
// divide-by-zero hold and signed-overflow rules. Multiply-accumulate
// (MADD/MADDU) is only decoded when MDU_MADD_EN is defined.
module mdu_compute
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] rt_safe;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;

    assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // The two special divide cases are resolved by muxing, so the divider
    // itself is fed a harmless divisor and never sees /0 or MIN/-1.
    assign div_zero = (rt == 32'd0);
    assign div_ovf  = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);
    assign rt_safe  = (div_zero || div_ovf) ? 32'd1 : rt;

    assign quo_s = $signed(rs) / $signed(rt_safe);
    assign rem_s = $signed(rs) % $signed(rt_safe);
    assign quo_u = rs / rt_safe;
    assign rem_u = rs % rt_safe;

    // Select the pending {HI,LO} for the presented operation.
    always_comb begin
        result = {hi, lo};
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                if (div_zero)     result = {hi, lo};
                else if (div_ovf) result = {32'd0, 32'h8000_0000};
                else              result = {rem_s, quo_s};
            end
            MD_DIVU: begin
                if (div_zero) result = {hi, lo};
                else          result = {rem_u, quo_u};
            end
`ifdef MDU_MADD_EN
            MD_MADD:  result = {hi, lo} + prod_s;
            MD_MADDU: result = {hi, lo} + prod_u;
`endif
            default:  result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit. Owns HI/LO, captures the result at
// acceptance into a pending register and commits it after a fixed busy
// period. Reports occupancy to the hazard unit. MDU_MADD_EN enables the
// MADD/MADDU accumulate operations; otherwise those codes are no-ops.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  md_op,
    input  logic        md_start,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        md_occupied,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] count_reg;
    logic [63:0]      pending_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic [63:0]      result;
    logic             accept;

    mdu_compute u_compute (
        .op     (md_op),
        .rs     (rs_val),
        .rt     (rt_val),
        .hi     (hi_reg),
        .lo     (lo_reg),
        .result (result)
    );

    assign busy        = (count_reg != '0);
    assign md_occupied = busy | (md_start & is_multi_cycle(md_op));
    assign accept      = md_start & ~Req & ~busy;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

    // Busy counter, pending result and HI/LO. A running operation ignores
    // Req and new starts; it commits on the edge where the count hits zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg   <= '0;
            pending_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else if (busy) begin
            count_reg <= count_reg - CNT_W'(1);
            if (count_reg == CNT_W'(1)) begin
                hi_reg <= pending_reg[63:32];
                lo_reg <= pending_reg[31:0];
            end
        end else if (accept) begin
            if (is_multi_cycle(md_op)) begin
                pending_reg <= result;
                count_reg   <= is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (md_op == MD_MTHI) begin
                hi_reg <= rs_val;
            end else if (md_op == MD_MTLO) begin
                lo_reg <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// multi-cycle sequences (Req during busy, overlapping start, reset mid-op)
// and randomized operations checked against an arithmetic reference model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef MDU_MADD_EN
    localparam int MADD_N = 5;
`else
    localparam int MADD_N = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic [3:0]  md_op;
    logic        md_start;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        md_occupied;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        req;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t tbl[$];

    mult_div_unit dut (
        .clk         (clk),
        .reset       (reset),
        .Req         (Req),
        .md_op       (md_op),
        .md_start    (md_start),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .busy        (busy),
        .md_occupied (md_occupied),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic tb_multi(input logic [3:0] op);
        if (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU) return 1'b1;
        if (op == MD_MADD || op == MD_MADDU) return (MADD_N != 0);
        return 1'b0;
    endfunction

    // Reference model: architectural effect of one presented operation.
    function automatic void model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                  input logic req, inout logic [31:0] h, inout logic [31:0] l,
                                  output int cyc);
        int a, b;
        longint sa, sb;
        longint unsigned ua, ub, acc;
        a = rs; b = rt; sa = a; sb = b; ua = rs; ub = rt;
        acc = {h, l};
        cyc = 0;
        if (req) return;
        case (op)
            MD_MULT:  begin {h, l} = sa * sb; cyc = MULT_N; end
            MD_MULTU: begin {h, l} = ua * ub; cyc = MULT_N; end
            MD_DIV: begin
                cyc = DIV_N;
                if (b == 0) begin end
                else if (a == 32'sh8000_0000 && b == -1) begin h = 0; l = 32'h8000_0000; end
                else begin l = a / b; h = a % b; end
            end
            MD_DIVU: begin
                cyc = DIV_N;
                if (rt != 0) begin l = rs / rt; h = rs % rt; end
            end
            MD_MTHI: h = rs;
            MD_MTLO: l = rs;
            MD_MADD:  if (MADD_N != 0) begin {h, l} = acc + longint'(sa * sb); cyc = MADD_N; end
            MD_MADDU: if (MADD_N != 0) begin {h, l} = acc + ua * ub; cyc = MADD_N; end
            default: ;
        endcase
    endfunction

    // Present one operation for a cycle, then count busy cycles (bounded).
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic req, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_cyc);
        logic [31:0] hi0, lo0;
        int n;
        hi0 = hi; lo0 = lo;
        md_op = op; rs_val = rs; rt_val = rt; Req = req; md_start = 1'b1;
        #1;
        check({name, " occupied"}, {31'd0, md_occupied}, {31'd0, tb_multi(op)});
        @(negedge clk);
        md_start = 1'b0; Req = 1'b0; md_op = MD_NOP;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            if (n == 1) begin
                check({name, " hi no-bypass"}, hi, hi0);
                check({name, " lo no-bypass"}, lo, lo0);
            end
            @(negedge clk);
        end
        check({name, " busy cycles"}, n, exp_cyc);
        check({name, " hi"}, hi, exp_hi);
        check({name, " lo"}, lo, exp_lo);
        $display("op %-10s rs=%08h rt=%08h req=%0b busy=%0d hi=%08h lo=%08h",
                 name, rs, rt, req, n, hi, lo);
    endtask

    task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] rs,
                           input logic [31:0] rt, input logic req, input logic [31:0] h,
                           input logic [31:0] l, input int cyc);
        vec_t v;
        v.name = name; v.op = op; v.rs = rs; v.rt = rt; v.req = req;
        v.exp_hi = h; v.exp_lo = l; v.exp_cyc = cyc;
        tbl.push_back(v);
    endtask

    initial begin
        int n, cyc;
        logic [3:0] ops [10];
        logic [31:0] corners [5];
        logic [3:0] rop;
        logic [31:0] rrs, rrt;
        logic rreq;

        reset = 1'b1; Req = 1'b0; md_start = 1'b0; md_op = MD_NOP; rs_val = 0; rt_val = 0;

        // Reset state; a start presented during reset must have no effect.
        @(negedge clk);
        md_start = 1'b1; md_op = MD_MTHI; rs_val = 32'hAAAA_AAAA;
        @(negedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset occupied", {31'd0, md_occupied}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        md_start = 1'b0; md_op = MD_NOP;
        reset = 1'b0;
        @(negedge clk);

        // Directed table (expected values worked out by hand, applied in order).
        add_vec("mthi",      MD_MTHI,  32'h11,        32'h0,        1'b0, 32'h11,        32'h0,        0);
        add_vec("mtlo",      MD_MTLO,  32'h22,        32'h0,        1'b0, 32'h11,        32'h22,       0);
        add_vec("divu/0",    MD_DIVU,  32'h5,         32'h0,        1'b0, 32'h11,        32'h22,       DIV_N);
        add_vec("mult",      MD_MULT,  32'hFFFF_FFFE, 32'h3,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N);
        add_vec("multu",     MD_MULTU, 32'hFFFF_FFFE, 32'h3,        1'b0, 32'h0000_0002, 32'hFFFF_FFFA, MULT_N);
        add_vec("div",       MD_DIV,   32'hFFFF_FFF9, 32'h2,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N);
        add_vec("div ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0,        32'h8000_0000, DIV_N);
        add_vec("mult+req",  MD_MULT,  32'h7,         32'h7,        1'b1, 32'h0,         32'h8000_0000, 0);
        add_vec("nop",       MD_NOP,   32'h1,         32'h1,        1'b0, 32'h0,         32'h8000_0000, 0);
        add_vec("undef",     4'hF,     32'h1,         32'h1,        1'b0, 32'h0,         32'h8000_0000, 0);
        add_vec("divu",      MD_DIVU,  32'd100,       32'd7,        1'b0, 32'd2,         32'd14,       DIV_N);
        add_vec("div 7/-2",  MD_DIV,   32'd7,         32'hFFFF_FFFE, 1'b0, 32'd1,        32'hFFFF_FFFD, DIV_N);
        add_vec("mthi 0",    MD_MTHI,  32'h0,         32'h0,        1'b0, 32'h0,         32'hFFFF_FFFD, 0);
        add_vec("mtlo -1",   MD_MTLO,  32'hFFFF_FFFF, 32'h0,        1'b0, 32'h0,         32'hFFFF_FFFF, 0);
`ifdef MDU_MADD_EN
        add_vec("maddu",     MD_MADDU, 32'h1,         32'h1,        1'b0, 32'h1,         32'h0,        MADD_N);
`else
        add_vec("maddu",     MD_MADDU, 32'h1,         32'h1,        1'b0, 32'h0,         32'hFFFF_FFFF, MADD_N);
`endif
        add_vec("madd",      MD_MADD,  32'hFFFF_FFFF, 32'h1,        1'b0, 32'h0,         32'hFFFF_FFFF, MADD_N);

        foreach (tbl[i])
            run_op(tbl[i].name, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].req,
                   tbl[i].exp_hi, tbl[i].exp_lo, tbl[i].exp_cyc);

        // Req (with a start) arriving in cycle 2 of a running DIV: DIV still commits.
        md_op = MD_DIVU; rs_val = 32'd100; rt_val = 32'd9; md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0; n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            if (n == 2) begin
                Req = 1'b1; md_start = 1'b1; md_op = MD_MULT; rs_val = 32'd3; rt_val = 32'd3;
            end else begin
                Req = 1'b0; md_start = 1'b0; md_op = MD_NOP;
            end
            @(negedge clk);
        end
        check("req-inflight busy cycles", n, DIV_N);
        check("req-inflight hi", hi, 32'd1);
        check("req-inflight lo", lo, 32'd11);
        $display("seq req-during-div busy=%0d hi=%08h lo=%08h", n, hi, lo);

        // Starts presented while busy are ignored.
        md_op = MD_MULTU; rs_val = 32'd3; rt_val = 32'd4; md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0; n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            md_start = 1'b0; md_op = MD_NOP;
            if (n == 2) begin md_start = 1'b1; md_op = MD_DIV; rs_val = 32'd1; rt_val = 32'd1; end
            if (n == 3) begin md_start = 1'b1; md_op = MD_MTHI; rs_val = 32'hDEAD; end
            if (n == 4) check("overlap hi held", hi, 32'd1);
            #1;
            if (n == 2) check("overlap occupied", {31'd0, md_occupied}, 32'd1);
            @(negedge clk);
        end
        check("overlap busy cycles", n, MULT_N);
        check("overlap hi", hi, 32'd0);
        check("overlap lo", lo, 32'd12);
        $display("seq overlap busy=%0d hi=%08h lo=%08h", n, hi, lo);

        // Reset in busy cycle 3 clears everything.
        md_op = MD_MULT; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3; md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0; md_op = MD_NOP; n = 0;
        while (busy === 1'b1 && n < 3) begin
            n++;
            if (n == 3) reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset hi", hi, 32'd0);
        check("midreset lo", lo, 32'd0);
        repeat (MULT_N) @(negedge clk);
        check("midreset no late commit lo", lo, 32'd0);
        $display("seq reset-mid-op busy=%0b hi=%08h lo=%08h", busy, hi, lo);

        // Randomized operations against the reference model.
        ops = '{MD_NOP, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MADDU, 4'hC};
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        m_hi = 32'd0; m_lo = 32'd0;
        for (int k = 0; k < 60; k++) begin
            rop  = ops[$urandom_range(0, 9)];
            rrs  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            rrt  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            rreq = ($urandom_range(0, 7) == 0);
            model(rop, rrs, rrt, rreq, m_hi, m_lo, cyc);
            run_op($sformatf("rnd%0d", k), rop, rrs, rrt, rreq, m_hi, m_lo, cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- EX-stage multiply/divide unit.
- Consumes the decoded EX-stage operands and the MD operation latched by the ID/EX pipeline register.
- Owns the architectural HI/LO registers and models fixed multi-cycle latency with a busy counter.
- Reports occupancy to the hazard unit so MD-class instructions in ID stall while an operation is in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Req  in  1  exception/interrupt request from M stage; suppresses the operation presented this cycle
- md_op  in  4  operation from EX: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU (package constants)
- md_start  in  1  EX holds a valid MD instruction (EX_MdWrite)
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- busy  out  1  operation in flight (counter != 0)
- md_occupied  out  1  busy | (md_start & starting op is multi-cycle); drives the hazard unit
- hi  out  32  current HI register
- lo  out  32  current LO register

## Operation
- Reset: HI=0, LO=0, counter=0, pending result=0; busy=0, md_occupied=0.
- An operation is accepted when md_start=1, Req=0 and busy=0.
- MULT/MULTU: 64-bit signed/unsigned product computed at acceptance into the pending register {phi,plo}; counter loaded with MULT_CYCLES.
- DIV/DIVU: plo=quotient, phi=remainder (signed: truncate toward zero, remainder takes dividend sign); counter loaded with DIV_CYCLES.
- Divide by zero: counter still loaded with DIV_CYCLES; pending = current {HI,LO}, so HI/LO are unchanged at completion.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: HI or LO written with rs_val at the accepting edge; no busy period.
- Counter decrements by 1 each cycle while nonzero.
- On the edge where the counter goes 1->0, {HI,LO} <= {phi,plo}.
- md_start while busy=1 is ignored. The hazard unit guarantees this never happens; the bench checks that state is unchanged if it does.
- Req=1: the instruction in EX is squashed and nothing is accepted.
- An operation already counting is architecturally committed and completes normally regardless of Req.
- md_op=NOP, or any undefined code, with md_start=1 is a no-op.

## Timing
- Accept at edge t: busy=1 from t+1 through t+N, where N is the loaded count. HI/LO hold the new value from t+N onward; busy=0 in the same cycle HI/LO become visible.
- md_occupied is combinational from md_start/md_op/busy, so a same-cycle following mfhi/mflo in ID stalls.
- hi/lo are register outputs. An MFHI/MFLO in EX reads them directly, with no bypass of an in-flight result.
- MTHI/MTLO value is visible on hi/lo the cycle after acceptance.
- reset wins over all other inputs.
- Reset mid-operation clears the counter and pending result; HI/LO return to 0.

## Configuration
- MDU_MADD_EN defined: MADD/MADDU accepted; {HI,LO} <= {HI,LO} + signed/unsigned product. The sum is taken against HI/LO at acceptance, with MULT_CYCLES latency.
- MDU_MADD_EN undefined: MADD/MADDU codes decode as no-op; busy stays 0; HI/LO unchanged.

## Structure
- Shared package mdu_pkg:
  - md_op 4-bit encodings (NOP=0, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU)
  - default latency constants
- The same encodings are used by the controller producing EX_MdWrite/md_op.
- One natural sub-module, mdu_compute: purely combinational. Inputs are op, rs, rt and current HI/LO; output is the 64-bit pending result including the div-by-zero and MADD rules.
- The top module keeps the counter, pending register, HI/LO and handshakes.

## Test plan
- MULT: rs=0xFFFFFFFE, rt=3 (-2 × 3).
  - busy high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU: same operands.
  - Then HI=0x00000002, LO=0xFFFFFFFA.
- DIV: rs=0xFFFFFFF9, rt=2 (-7 / 2).
  - busy 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU: rt=0, HI/LO preset via MTHI 0x11 / MTLO 0x22.
  - After 10 cycles HI=0x11, LO=0x22.
- Req and md_start together:
  - MULT with Req=1 and md_start=1 in the same cycle: busy stays 0 and HI/LO unchanged.
  - Req asserted at cycle 2 of an in-flight DIV: result still commits at cycle 10.
- Overlap and reset:
  - Second md_start during busy: ignored; first result intact.
  - Reset at busy cycle 3: busy=0 and HI=LO=0 next cycle.
  - With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU 1×1 gives HI=1, LO=0.
